local_port: RTL and testbench
=============================

LOCAL_PORT -- requirements
Module: local_port

Interface
REQ-001 Parameter: DEPTH, 4, injection FIFO depth in flits; legal values are 2, 4 and 8.
REQ-002 Parameter: FW, 10, flit width; bit FW-1 is the valid bit and bits FW-2:0 are opaque to this block.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 Port: core_flit  input  FW  flit offered by the local core for injection.
REQ-006 Port: core_push  input  1  push core_flit into the injection FIFO this cycle.
REQ-007 Port: core_full  output  1  injection FIFO holds DEPTH flits.
REQ-008 Port: link_v  input  4  valid bits of router link inputs this cycle, in order {nin[9],sin[9],ein[9],win[9]}.
REQ-009 Port: lin  output  FW  injection flit to the router local input.
REQ-010 Port: lout  input  FW  ejection flit from the router local output.
REQ-011 Port: ej_flit  output  FW  registered ejected flit.
REQ-012 Port: ej_valid  output  1  ej_flit holds a new flit this cycle.
REQ-013 Port: inj_count  output  4  current FIFO occupancy.
REQ-014 Port: drop_cnt  output  8  number of pushes refused while full.

Function
REQ-015 The FIFO SHALL be a circular buffer with wrapping read/write pointers and occupancy inj_count in the range 0..DEPTH.
REQ-016 core_full SHALL equal (inj_count == DEPTH), derived from registered state only.
REQ-017 Injection is permitted when inj_count > 0 and the number of ones in link_v is at most 3; this test is combinational in the same cycle.
REQ-018 When injection is permitted, lin SHALL be the head flit with bit FW-1 forced to 1; otherwise lin SHALL be all zeros.
REQ-019 On each rising edge where injection is permitted, the head SHALL pop.
REQ-020 A push with core_push=1 and inj_count<DEPTH SHALL write core_flit at the tail.
REQ-021 A push with inj_count==DEPTH SHALL be discarded even if a pop occurs in the same cycle, and drop_cnt SHALL increment, saturating at 255.
REQ-022 A simultaneous push and pop with 0<inj_count<DEPTH SHALL leave inj_count unchanged and preserve FIFO order.
REQ-023 There is no bypass path; a flit pushed at edge t SHALL appear on lin no earlier than the cycle after edge t.
REQ-024 Ejection SHALL have 1-cycle latency: at each edge, ej_valid<=lout[FW-1] and ej_flit<=(lout[FW-1] ? lout : 0).
REQ-025 Ejection SHALL never stall; the block asserts no backpressure toward the router.

Reset
REQ-026 While rst_n=0: pointers, inj_count, drop_cnt, ej_flit and ej_valid SHALL be 0, lin SHALL be 0, and core_full SHALL be 0.
REQ-027 Asserting reset mid-operation SHALL discard all queued flits immediately, without waiting for a clock edge.
REQ-028 Pushes presented in the first edge after rst_n rises SHALL be accepted normally.

Verification
REQ-029 Reset; push 10'h02D then 10'h12C with link_v=4'b1111 -> lin=0 and inj_count=2 are held; set link_v=4'b0111 -> lin=10'h22D then 10'h32C on consecutive cycles, and inj_count returns to 0.
REQ-030 Push 5 flits back-to-back with link_v=4'b1111 (DEPTH=4) -> core_full=1 after the 4th push, the 5th push is dropped, and drop_cnt=1.
REQ-031 Full FIFO, link_v=4'b0000, and push in the same cycle -> one pop occurs, the push is dropped, inj_count=3, and drop_cnt increments.
REQ-032 Hold push and pop every cycle for 10 cycles with inj_count=2 -> order is preserved across pointer wrap and inj_count stays 2.
REQ-033 lout=10'h224, then 10'h000, then 10'h3FF -> on the following edges ej_valid/ej_flit = 1/10'h224, 0/10'h000, 1/10'h3FF.
REQ-034 Assert rst_n=0 between edges with inj_count=3 -> inj_count=0 and lin=0 before the next edge.

Source files
------------

// File: rtl/local_port.sv
// Local port of a mesh router node: injection FIFO from the local core toward
// the router local input, and a one-stage registered ejection path from the
// router local output back to the core.
//
// Injection flits are queued in a small circular buffer. The head leaves the
// buffer on any cycle where the router has at least one idle link input, so
// the local flit never competes with four simultaneous through-flits.
// Ejection is a plain register stage with no backpressure.
module local_port #(
   parameter int DEPTH = 4,   // 2, 4 or 8
   parameter int FW    = 10   // bit FW-1 is the flit valid bit
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [FW-1:0] core_flit,
   input  logic          core_push,
   output logic          core_full,
   input  logic [3:0]    link_v,
   output logic [FW-1:0] lin,
   input  logic [FW-1:0] lout,
   output logic [FW-1:0] ej_flit,
   output logic          ej_valid,
   output logic [3:0]    inj_count,
   output logic [7:0]    drop_cnt
);

   localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);
   localparam logic [FW-1:0] VALID_BIT = {1'b1, {(FW-1){1'b0}}};

   logic [FW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          fifo_full;
   logic          inj_ok;
   logic          push_ok;
   logic          push_drop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Full is taken from the registered count only, so a same-cycle pop never
   // opens room for a push on a full buffer.
   assign fifo_full = (inj_count == DEPTH_C);
   assign core_full = fifo_full;

   // All four link inputs busy means the router has no slot for local traffic.
   assign inj_ok    = (inj_count != 4'd0) && !(&link_v);
   assign push_ok   = core_push && !fifo_full;
   assign push_drop = core_push && fifo_full;

   // Head flit is presented with its valid bit forced; idle cycles drive zero.
   always_comb begin
      lin = '0;
      if (inj_ok) begin
         lin = mem[rd_ptr] | VALID_BIT;
      end
   end

   // Storage array; contents are meaningless outside the occupied window, so
   // it carries no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= core_flit;
      end
   end

   // Pointers and occupancy; reset empties the queue immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         inj_count <= 4'd0;
      end else begin
         if (push_ok) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (inj_ok) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push_ok, inj_ok})
            2'b10:   inj_count <= inj_count + 4'd1;
            2'b01:   inj_count <= inj_count - 4'd1;
            default: inj_count <= inj_count;
         endcase
      end
   end

   // Refused-push counter, saturating so it never wraps back to a small value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else if (push_drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Ejection stage: capture valid flits, zero the data on idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ej_valid <= 1'b0;
         ej_flit  <= '0;
      end else begin
         ej_valid <= lout[FW-1];
         ej_flit  <= lout[FW-1] ? lout : '0;
      end
   end

endmodule

// File: tb/tb_local_port.sv
module tb_local_port;

   logic       clk;
   logic       rst_n;
   logic [9:0] core_flit;
   logic       core_push;
   logic       core_full;
   logic [3:0] link_v;
   logic [9:0] lin;
   logic [9:0] lout;
   logic [9:0] ej_flit;
   logic       ej_valid;
   logic [3:0] inj_count;
   logic [7:0] drop_cnt;

   int compared   = 0;
   int mismatched = 0;

   local_port #(.DEPTH(4), .FW(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .core_flit (core_flit),
      .core_push (core_push),
      .core_full (core_full),
      .link_v    (link_v),
      .lin       (lin),
      .lout      (lout),
      .ej_flit   (ej_flit),
      .ej_valid  (ej_valid),
      .inj_count (inj_count),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 2 time units past it.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n     = 1'b0;
      core_flit = '0;
      core_push = 1'b0;
      link_v    = 4'b0000;
      lout      = '0;
      #3;
      check("rst_count", inj_count, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_lin", lin, 0);
      check("rst_full", core_full, 0);
      check("rst_ejv", ej_valid, 0);
      check("rst_ejf", ej_flit, 0);
      #4;
      rst_n = 1'b1;

      // Two pushes while all links busy, then release one link.
      link_v = 4'b1111; core_push = 1'b1; core_flit = 10'h02D;
      step();
      check("first_push_accepted", inj_count, 1);
      check("blocked_lin_a", lin, 0);
      core_flit = 10'h12C;
      step();
      core_push = 1'b0;
      check("two_queued", inj_count, 2);
      check("blocked_lin_b", lin, 0);
      step();
      check("held_count", inj_count, 2);
      check("held_lin", lin, 0);
      link_v = 4'b0111;
      #1;
      check("inj_first", lin, 10'h22D);
      step();
      check("inj_second", lin, 10'h32C);
      check("count_after_pop", inj_count, 1);
      step();
      check("drained_count", inj_count, 0);
      check("drained_lin", lin, 0);

      // Overfill with links busy.
      link_v = 4'b1111; core_push = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         core_flit = 10'(i);
         step();
         if (i == 3) check("not_full_at_3", core_full, 0);
         if (i == 4) check("full_at_4", core_full, 1);
      end
      check("full_count", inj_count, 4);
      check("drop_one", drop_cnt, 1);
      check("still_full", core_full, 1);

      // Full buffer, pop and push in the same cycle: push refused.
      link_v = 4'b0000; core_flit = 10'h0AA;
      #1;
      check("full_head", lin, 10'h201);
      step();
      core_push = 1'b0;
      check("pop_full_count", inj_count, 3);
      check("pop_full_drop", drop_cnt, 2);
      check("pop_full_full", core_full, 0);
      for (int i = 2; i <= 4; i++) begin
         check("drain_order", lin, 32'h200 + 32'(i));
         step();
      end
      check("drain_empty", inj_count, 0);
      check("drain_lin", lin, 0);

      // Steady push+pop at occupancy 2 across pointer wrap.
      link_v = 4'b1111; core_push = 1'b1;
      core_flit = 10'h040; step();
      core_flit = 10'h041; step();
      check("steady_setup", inj_count, 2);
      link_v = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         core_flit = 10'h042 + 10'(i);
         #1;
         check("steady_head", lin, 32'h240 + 32'(i));
         step();
         check("steady_count", inj_count, 2);
      end
      core_push = 1'b0;
      #1;
      check("steady_tail_a", lin, 10'h24A);
      step();
      check("steady_tail_b", lin, 10'h24B);
      step();
      check("steady_empty", inj_count, 0);

      // Ejection path.
      lout = 10'h224; step();
      check("ej_v1", ej_valid, 1);
      check("ej_f1", ej_flit, 10'h224);
      lout = 10'h000; step();
      check("ej_v2", ej_valid, 0);
      check("ej_f2", ej_flit, 10'h000);
      lout = 10'h3FF; step();
      check("ej_v3", ej_valid, 1);
      check("ej_f3", ej_flit, 10'h3FF);
      lout = 10'h1AB; step();
      check("ej_v4", ej_valid, 0);
      check("ej_f4", ej_flit, 10'h000);
      lout = 10'h000;

      // Mid-cycle reset with three queued flits.
      link_v = 4'b1111; core_push = 1'b1;
      core_flit = 10'h011; step();
      core_flit = 10'h012; step();
      core_flit = 10'h013; step();
      core_push = 1'b0;
      check("pre_rst_count", inj_count, 3);
      link_v = 4'b0000;
      #1;
      check("pre_rst_lin", lin, 10'h211);
      rst_n = 1'b0;
      #1;
      check("async_rst_count", inj_count, 0);
      check("async_rst_lin", lin, 0);
      check("async_rst_full", core_full, 0);
      check("async_rst_drop", drop_cnt, 0);
      #1;
      rst_n = 1'b1;

      // Push on first edge after reset release, then saturate drop_cnt.
      link_v = 4'b1111; core_push = 1'b1; core_flit = 10'h077;
      step();
      check("post_rst_push", inj_count, 1);
      for (int i = 0; i < 3; i++) step();
      check("sat_full", core_full, 1);
      check("sat_drop0", drop_cnt, 0);
      for (int i = 0; i < 254; i++) step();
      check("sat_254", drop_cnt, 254);
      step();
      check("sat_255", drop_cnt, 255);
      step();
      check("sat_hold", drop_cnt, 255);
      core_push = 1'b0;
      link_v = 4'b1110;
      #1;
      check("post_rst_head", lin, 10'h277);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
